// File: rtl/timer_key_ctrl.sv
// Key front end for the stopwatch: synchronizes and debounces a push-button and drives the run/stop level.
// Define TIMER_KEY_LONG_PRESS_EN for long-press clear (start toggles on release, clr pulses on a long hold).
module timer_key_ctrl #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic start,
  output logic clr
);

  localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic KEY_REL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  logic [1:0]      sync_q;
  logic            k_s;
  logic [1:0]      state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic            press_acc_s;
  logic            start_q, start_d;
`ifdef TIMER_KEY_LONG_PRESS_EN
  logic            rel_acc_s;
`endif

  // Two-stage synchronizer holding the raw pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {KEY_REL, KEY_REL};
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign k_s       = sync_q[1] ^ KEY_REL;
  assign cnt_inc_s = (cnt_q == DB_LAST) ? cnt_q : cnt_q + DB_W'(1);

  // Debounce FSM next-state; acceptance fires on the sample that brings the count to DB_LAST
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_acc_s = 1'b0;
`ifdef TIMER_KEY_LONG_PRESS_EN
    rel_acc_s   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (k_s) begin
          state_d = ST_DB_PRESS;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DB_PRESS: begin
        if (!k_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == DB_LAST) begin
            press_acc_s = 1'b1;
            state_d     = ST_PRESSED;
          end else begin
            state_d = ST_DB_PRESS;
          end
        end
      end
      ST_PRESSED: begin
        if (!k_s) begin
          state_d = ST_DB_RELEASE;
          cnt_d   = '0;
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_DB_RELEASE: begin
        if (k_s) begin
          state_d = ST_PRESSED;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == DB_LAST) begin
`ifdef TIMER_KEY_LONG_PRESS_EN
            rel_acc_s = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DB_RELEASE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and debounce counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TIMER_KEY_LONG_PRESS_EN
  localparam int LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
  localparam int HOLD_W      = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
  logic              rel_acc_q;
  logic              clr_q, clr_d;
  logic              held_s;

  // Hold timer; a long hold clears the run level and suppresses the toggle on its release
  always_comb begin
    held_s = (state_q == ST_PRESSED) || (state_q == ST_DB_RELEASE);
    if (press_acc_s) begin
      hold_d = '0;
    end else if (held_s && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_W'(1);
    end else begin
      hold_d = hold_q;
    end
    clr_d = held_s && (hold_q == HOLD_MAX) && !long_q;
    if (press_acc_s) begin
      long_d = 1'b0;
    end else if (clr_d) begin
      long_d = 1'b1;
    end else begin
      long_d = long_q;
    end
    if (clr_d) begin
      start_d = 1'b0;
    end else if (rel_acc_q && !long_q) begin
      start_d = ~start_q;
    end else begin
      start_d = start_q;
    end
  end

  // Output and long-press registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      long_q    <= 1'b0;
      rel_acc_q <= 1'b0;
      clr_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      long_q    <= long_d;
      rel_acc_q <= rel_acc_s;
      clr_q     <= clr_d;
      start_q   <= start_d;
    end
  end

  assign clr = clr_q;
`else
  logic press_acc_q;

  always_comb begin
    if (press_acc_q) begin
      start_d = ~start_q;
    end else begin
      start_d = start_q;
    end
  end

  // Toggle one cycle after press acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_acc_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      press_acc_q <= press_acc_s;
      start_q     <= start_d;
    end
  end

  assign clr = 1'b0;
`endif

  assign start = start_q;

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Directed bench for timer_key_ctrl at CLK_HZ=1000 (20-cycle debounce, 100-cycle long press).
module tb_timer_key_ctrl;

  logic clk;
  logic rst;
  logic key_in;
  logic start;
  logic clr;

  int n_cmp = 0;
  int n_err = 0;

  timer_key_ctrl #(
    .CLK_HZ(1000),
    .DEBOUNCE_MS(20),
    .LONG_MS(100),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .start(start),
    .clr(clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b0;
    key_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_async_start", start, 1'b0);
    check("rst_async_clr", clr, 1'b0);
    edges(3);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      edges(1);
      check("idle_start", start, 1'b0);
      check("idle_clr", clr, 1'b0);
    end

`ifndef TIMER_KEY_LONG_PRESS_EN
    // clean 50-cycle press: toggle lands on the 23rd edge after the fall
    key_in = 1'b0;
    edges(22);
    check("press_pre", start, 1'b0);
    edges(1);
    check("press_t23", start, 1'b1);
    edges(27);
    key_in = 1'b1;
    edges(40);
    check("after_release", start, 1'b1);
    check("clr_tied", clr, 1'b0);

    for (int i = 0; i < 5; i++) begin
      key_in = 1'b0;
      edges(2);
      key_in = 1'b1;
      edges(1);
    end
    edges(30);
    check("bounce", start, 1'b1);

    key_in = 1'b0;
    edges(19);
    key_in = 1'b1;
    edges(30);
    check("glitch19", start, 1'b1);

    key_in = 1'b0;
    edges(20);
    key_in = 1'b1;
    edges(2);
    check("glitch20_pre", start, 1'b1);
    edges(1);
    check("glitch20_toggle", start, 1'b0);
    edges(40);
    check("glitch20_hold", start, 1'b0);

    // second press with a 10-cycle release glitch in the middle
    key_in = 1'b0;
    edges(23);
    check("press2", start, 1'b1);
    edges(10);
    key_in = 1'b1;
    edges(10);
    key_in = 1'b0;
    edges(20);
    key_in = 1'b1;
    edges(40);
    check("hi_glitch", start, 1'b1);

    // reset while DB_PRESS count is 10
    key_in = 1'b0;
    edges(13);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_start", start, 1'b0);
    check("rst_mid_clr", clr, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    edges(22);
    check("rst_mid_pre", start, 1'b0);
    edges(1);
    check("rst_mid_t23", start, 1'b1);
    edges(27);
    key_in = 1'b1;
    edges(40);

    key_in = 1'b0;
    edges(23);
    check("press3", start, 1'b0);
    edges(27);
    key_in = 1'b1;
    edges(40);
    check("press3_rel", start, 1'b0);
    check("clr_end", clr, 1'b0);
`else
    // short press toggles only after release acceptance
    key_in = 1'b0;
    edges(30);
    check("short_no_press_toggle", start, 1'b0);
    edges(20);
    key_in = 1'b1;
    edges(22);
    check("short_pre", start, 1'b0);
    edges(1);
    check("short_t23", start, 1'b1);
    edges(20);

    key_in = 1'b0;
    edges(122);
    check("long_pre_clr", clr, 1'b0);
    check("long_pre_start", start, 1'b1);
    edges(1);
    check("long_clr", clr, 1'b1);
    check("long_start0", start, 1'b0);
    edges(1);
    check("long_clr_1wide", clr, 1'b0);
    edges(26);
    check("long_no_repeat", clr, 1'b0);
    key_in = 1'b1;
    edges(40);
    check("long_release_start", start, 1'b0);
    check("long_release_clr", clr, 1'b0);

    key_in = 1'b0;
    edges(50);
    key_in = 1'b1;
    edges(22);
    check("short2_pre", start, 1'b0);
    edges(1);
    check("short2_t23", start, 1'b1);
    check("short2_clr", clr, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
